// File: rtl/periodic_timer_master.sv
// Periodic timer bus master: reads the timer once, programs a compare value, then
// re-arms it by fixed increments on every acknowledged interrupt (drift-free).
module periodic_timer_master #(
  parameter logic [31:0] CYCLE_ADDR = 32'hffff001c,
  parameter logic [31:0] ACK_ADDR   = 32'hffff006c
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] period,
  input  logic [31:0] cycle,
  input  logic        TimerInterrupt,
  input  logic        TimerAddress,
  output logic [31:0] address,
  output logic [31:0] data,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] ticks,
  output logic        tick,
  output logic        busy,
  output logic        error,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WAIT  = 3'd3,
    ACK   = 3'd4,
    ERROR = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] ticks_q, ticks_d;
  logic [31:0] target_q, target_d;
  logic [31:0] period_q, period_d;

  // Bus outputs decode from state alone, so an async reset drops strobes at once.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ticks_q  <= 32'd0;
      target_q <= 32'd0;
      period_q <= 32'd2;
    end else begin
      state_q  <= state_d;
      ticks_q  <= ticks_d;
      target_q <= target_d;
      period_q <= period_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ticks_d  = ticks_q;
    target_d = target_q;
    period_d = period_q;
    address  = 32'd0;
    data     = 32'd0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    tick     = 1'b0;
    busy     = 1'b1;
    error    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (enable) begin
          state_d  = READ;
          period_d = (period < 32'd2) ? 32'd2 : period;
        end
      end
      READ: begin
        address  = CYCLE_ADDR;
        MemRead  = 1'b1;
        target_d = cycle + period_q;
        state_d  = TimerAddress ? WRITE : ERROR;
      end
      WRITE: begin
        address  = CYCLE_ADDR;
        data     = target_q;
        MemWrite = 1'b1;
        state_d  = WAIT;
      end
      WAIT: begin
        if (TimerInterrupt) state_d = ACK;
        else if (!enable)   state_d = IDLE;
      end
      ACK: begin
        // Advance from the previous compare value, never from a fresh read.
        address  = ACK_ADDR;
        MemWrite = 1'b1;
        tick     = 1'b1;
        ticks_d  = ticks_q + 32'd1;
        target_d = target_q + period_q;
        state_d  = enable ? WRITE : IDLE;
      end
      ERROR: begin
        busy  = 1'b0;
        error = 1'b1;
      end
      default: begin
        busy    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign ticks     = ticks_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_periodic_timer_master.sv
// Directed + randomized bench for periodic_timer_master; expected compare values
// come from a simple arithmetic model (first = cycle + max(period,2), then += period).
module tb_periodic_timer_master;

  localparam logic [31:0] CYCLE_ADDR = 32'hffff001c;
  localparam logic [31:0] ACK_ADDR   = 32'hffff006c;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] period = 32'd0;
  logic [31:0] cycle = 32'd0;
  logic        TimerInterrupt = 1'b0;
  logic        TimerAddress = 1'b1;
  logic [31:0] address, data, ticks;
  logic        MemRead, MemWrite, tick, busy, error;
  logic [2:0]  state_dbg;

  periodic_timer_master #(.CYCLE_ADDR(CYCLE_ADDR), .ACK_ADDR(ACK_ADDR)) dut (
    .clock(clock), .reset(reset), .enable(enable), .period(period), .cycle(cycle),
    .TimerInterrupt(TimerInterrupt), .TimerAddress(TimerAddress),
    .address(address), .data(data), .MemRead(MemRead), .MemWrite(MemWrite),
    .ticks(ticks), .tick(tick), .busy(busy), .error(error), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_ticks, m_target, m_period;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // driver: advance one clock, then settle away from the edge
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_write(input string tag);
    chk({tag, "_strobe"}, 32'(MemWrite), 32'd1);
    chk({tag, "_rd"}, 32'(MemRead), 32'd0);
    chk({tag, "_addr"}, address, CYCLE_ADDR);
    chk({tag, "_sb_depth"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) chk({tag, "_data"}, data, exp_q.pop_front());
  endtask

  task automatic check_ack(input string tag);
    chk({tag, "_addr"}, address, ACK_ADDR);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_strobe"}, 32'(MemWrite), 32'd1);
    chk({tag, "_tick"}, 32'(tick), 32'd1);
  endtask

  task automatic check_bus_idle(input string tag);
    chk({tag, "_strobes"}, 32'({MemRead, MemWrite}), 32'd0);
    chk({tag, "_addr"}, address, 32'd0);
  endtask

  initial begin
    logic [31:0] p_in, c_in;
    int n_irq, gap;
    bit stop_in_ack;

    // ---- reset state
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ticks", ticks, 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    check_bus_idle("rst");
    m_ticks = 32'd0;

    // ---- directed start: period=100, cycle=500
    reset = 1'b1;
    enable = 1'b1;
    period = 32'd100;
    TimerAddress = 1'b1;
    step();                      // READ
    cycle = 32'd500;
    period = 32'd7;              // must not affect this run
    TimerInterrupt = 1'b1;       // ignored outside WAIT
    chk("start_rd", 32'(MemRead), 32'd1);
    chk("start_rd_addr", address, CYCLE_ADDR);
    chk("start_busy", 32'(busy), 32'd1);
    exp_q.push_back(32'd600);
    step();                      // WRITE
    TimerInterrupt = 1'b0;
    check_write("start_wr");
    step();                      // WAIT
    chk("wait_busy", 32'(busy), 32'd1);
    check_bus_idle("wait");
    step();
    chk("wait_hold", 32'(busy), 32'd1);
    TimerInterrupt = 1'b1;
    step();                      // ACK
    check_ack("ack1");
    step();                      // WRITE
    TimerInterrupt = 1'b0;
    chk("ack1_ticks", ticks, 32'd1);
    chk("ack1_tick_low", 32'(tick), 32'd0);
    exp_q.push_back(32'd700);
    check_write("rearm1");
    step();                      // WAIT
    TimerInterrupt = 1'b1;
    step();                      // ACK
    TimerInterrupt = 1'b0;
    check_ack("ack2");
    step();                      // WRITE
    chk("ack2_ticks", ticks, 32'd2);
    exp_q.push_back(32'd800);
    check_write("rearm2");
    step();                      // WAIT
    enable = 1'b0;
    step();                      // IDLE
    chk("stop_wait_busy", 32'(busy), 32'd0);
    check_bus_idle("stop_wait");
    step();
    chk("idle_stays", 32'(busy), 32'd0);
    m_ticks = 32'd2;

    // ---- randomized runs against the arithmetic model
    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 3) == 0) p_in = 32'($urandom_range(0, 1));
      else if ($urandom_range(0, 3) == 0) p_in = $urandom;
      else p_in = 32'($urandom_range(2, 5000));
      c_in = $urandom;
      m_period = (p_in < 32'd2) ? 32'd2 : p_in;
      m_target = c_in + m_period;
      exp_q.push_back(m_target);
      period = p_in;
      enable = 1'b1;
      step();                    // READ
      cycle = c_in;
      period = $urandom;
      chk("rnd_rd", 32'(MemRead), 32'd1);
      chk("rnd_rd_addr", address, CYCLE_ADDR);
      step();                    // WRITE
      check_write("rnd_wr");
      step();                    // WAIT
      n_irq = $urandom_range(1, 3);
      stop_in_ack = 1'($urandom_range(0, 1));
      for (int k = 0; k < n_irq; k++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          step();
          chk("rnd_wait_busy", 32'(busy), 32'd1);
          check_bus_idle("rnd_wait");
        end
        TimerInterrupt = 1'b1;
        step();                  // ACK
        TimerInterrupt = 1'b0;
        check_ack("rnd_ack");
        m_ticks = m_ticks + 32'd1;
        m_target = m_target + m_period;
        if (k == n_irq - 1 && stop_in_ack) begin
          enable = 1'b0;
          step();                // IDLE
          chk("rnd_ack_stop_busy", 32'(busy), 32'd0);
          chk("rnd_ack_stop_ticks", ticks, m_ticks);
        end else begin
          exp_q.push_back(m_target);
          step();                // WRITE
          check_write("rnd_rearm");
          chk("rnd_ticks", ticks, m_ticks);
          step();                // WAIT
        end
      end
      if (enable) begin
        enable = 1'b0;
        step();                  // IDLE
        chk("rnd_stop_busy", 32'(busy), 32'd0);
        check_bus_idle("rnd_stop");
      end
    end

    // ---- clamp and wrap
    reset = 1'b0;
    #1;
    chk("rst2_ticks", ticks, 32'd0);
    step();
    reset = 1'b1;
    period = 32'd0;
    enable = 1'b1;
    step();                      // READ
    cycle = 32'hffffffff;
    exp_q.push_back(32'h00000001);
    step();                      // WRITE
    check_write("clamp_wr");
    step();                      // WAIT
    force dut.ticks_q = 32'hffffffff;
    step();
    release dut.ticks_q;
    chk("preset_ticks", ticks, 32'hffffffff);
    TimerInterrupt = 1'b1;
    step();                      // ACK
    TimerInterrupt = 1'b0;
    enable = 1'b0;               // falls mid-ACK: access still completes
    check_ack("wrap_ack");
    step();                      // IDLE
    chk("wrap_ticks", ticks, 32'd0);
    chk("wrap_idle_busy", 32'(busy), 32'd0);
    check_bus_idle("wrap_idle");

    // ---- decode failure
    enable = 1'b1;
    period = 32'd50;
    step();                      // READ
    TimerAddress = 1'b0;
    chk("err_rd", 32'(MemRead), 32'd1);
    step();                      // ERROR
    TimerAddress = 1'b1;
    for (int e = 0; e < 4; e++) begin
      chk("err_flag", 32'(error), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      check_bus_idle("err_bus");
      TimerInterrupt = 1'($urandom_range(0, 1));
      enable = 1'($urandom_range(0, 1));
      step();
    end
    TimerInterrupt = 1'b0;
    reset = 1'b0;
    #1;
    chk("err_cleared", 32'(error), 32'd0);
    step();

    // ---- async reset mid-WRITE
    reset = 1'b1;
    enable = 1'b1;
    period = 32'd20;
    step();                      // READ
    cycle = 32'd1000;
    exp_q.push_back(32'd1020);
    step();                      // WRITE
    check_write("ar_wr");
    step();                      // WAIT
    TimerInterrupt = 1'b1;
    step();                      // ACK
    TimerInterrupt = 1'b0;
    exp_q.push_back(32'd1040);
    step();                      // WRITE
    chk("ar_pre_ticks", ticks, 32'd1);
    check_write("ar_rearm");
    #2;
    reset = 1'b0;
    #1;                          // still before the next rising edge
    chk("ar_memwrite", 32'(MemWrite), 32'd0);
    chk("ar_ticks", ticks, 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b1;
    enable = 1'b0;
    step();
    chk("ar_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/periodic_timer_master.md
PERIODIC_TIMER_MASTER -- requirements
Module: periodic_timer_master

Interface
REQ-001 Parameter CYCLE_ADDR, default 32'hffff001c, timer cycle/compare register address.
REQ-002 Parameter ACK_ADDR, default 32'hffff006c, timer interrupt-acknowledge address.
REQ-003 clock  input  1  single clock; all state SHALL change on its rising edge, except reset.
REQ-004 reset  input  1  asynchronous, active-low; 0 SHALL force the reset state immediately.
REQ-005 enable  input  1  1 = run periodic servicing; 0 = stop at the next safe point.
REQ-006 period  input  32  interrupt spacing in cycles, sampled on leaving IDLE.
REQ-007 cycle  input  32  read data from the timer, valid combinationally while MemRead=1.
REQ-008 TimerInterrupt  input  1  interrupt line from the timer.
REQ-009 TimerAddress  input  1  timer address-decode hit for the current access.
REQ-010 address  output  32  bus address.
REQ-011 data  output  32  bus write data.
REQ-012 MemRead, MemWrite  output  1 each  bus strobes, mutually exclusive, one cycle per access.
REQ-013 ticks  output  32  count of acknowledged interrupts.
REQ-014 tick  output  1  one-cycle pulse per acknowledge.
REQ-015 busy  output  1  1 in any state other than IDLE and ERROR.
REQ-016 error  output  1  sticky decode-failure flag.

Function
REQ-017 FSM states SHALL be exactly IDLE, READ, WRITE, WAIT, ACK, ERROR.
REQ-018 In IDLE, WAIT and ERROR: address=0, data=0, MemRead=0, MemWrite=0.
REQ-019 IDLE: enable=1 -> READ; latch period_reg = max(period, 2).
REQ-020 READ: address=CYCLE_ADDR, MemRead=1; target = cycle + period_reg mod 2^32 captured at the clock edge; TimerAddress=0 -> ERROR, else -> WRITE.
REQ-021 WRITE: address=CYCLE_ADDR, data=target, MemWrite=1 -> WAIT.
REQ-022 WAIT: TimerInterrupt=1 -> ACK (priority); else enable=0 -> IDLE; else stay.
REQ-023 ACK: address=ACK_ADDR, data=0, MemWrite=1, tick=1, ticks += 1 mod 2^32; target += period_reg mod 2^32; enable=1 -> WRITE, enable=0 -> IDLE.
REQ-024 Reprogramming after ACK SHALL NOT re-read cycle, so the interrupt interval is drift-free (exactly period_reg cycles).
REQ-025 enable falling in READ, WRITE or ACK SHALL NOT abort that access; it takes effect at the next state decision.
REQ-026 ERROR: error=1, busy=0, bus idle; exit only via reset.
REQ-027 Minimum latency enable=1 -> first MemWrite of target: 3 cycles (IDLE, READ, WRITE).
REQ-028 TimerInterrupt SHALL be ignored in every state except WAIT.
REQ-029 ticks wraps 32'hffffffff -> 0; target addition wraps silently.
REQ-030 period changes while busy SHALL take effect only after the next pass through IDLE.

Reset
REQ-031 reset=0 SHALL asynchronously set state=IDLE, ticks=0, target=0, period_reg=2, error=0, tick=0, busy=0, and deassert both strobes.
REQ-032 Reset mid-access SHALL drop MemRead/MemWrite in the same cycle, with no partial write.
REQ-033 Release of reset SHALL take effect at the next rising clock edge, starting in IDLE.

Verification
REQ-034 Start: period=100, enable=1, cycle=500 in READ -> MemRead at CYCLE_ADDR, then MemWrite data=600, then busy=1 in WAIT.
REQ-035 Periodic: after the start above, assert TimerInterrupt once per compare match -> ACK write to ACK_ADDR, tick pulses, ticks=1, next MemWrite data=700, then 800 on the second interrupt.
REQ-036 Clamp/wrap: period=0, cycle=32'hffffffff -> target=32'h00000001; preset ticks=32'hffffffff, one ACK -> ticks=0.
REQ-037 Stop: enable=0 during ACK -> ACK completes (ticks increments), next state IDLE; enable=0 in WAIT -> IDLE next cycle, no bus access.
REQ-038 Error: TimerAddress=0 during READ -> error=1 and busy=0 permanently, no MemWrite issued; cleared only by reset=0.
REQ-039 Async reset: reset=0 mid-WRITE between clock edges -> MemWrite=0 and ticks=0 immediately, with no clock edge required.
